// File: rtl/fwd_hazard_ctrl_pkg.sv
// fwd_hazard_ctrl_pkg: shared forwarding-select encodings, stall FSM states and register width
package fwd_hazard_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  typedef enum logic {RUN, STALL} state_t;
endpackage

// File: rtl/fwd_src_sel.sv
// fwd_src_sel: picks the forwarding source for one operand from the EX/MEM destination tags
module fwd_src_sel #(
  parameter int REG_W = fwd_hazard_ctrl_pkg::REG_W
) (
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  logic             exV,
  input  logic             exRW,
  input  logic [REG_W-1:0] exDst,
  input  logic             memV,
  input  logic             memRW,
  input  logic [REG_W-1:0] memDst,
  output logic [1:0]       sel
);
  import fwd_hazard_ctrl_pkg::*;
  logic exHit, memHit;
  assign exHit = used && exV && exRW && exDst != '0 && exDst == src;
  assign memHit = used && memV && memRW && memDst != '0 && memDst == src;
  assign sel = exHit ? FWD_EXMEM : memHit ? FWD_MEMWB : FWD_REG;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: registered EX operand forwarding selects and load-use stall sequencing
module fwd_hazard_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int REG_W = fwd_hazard_ctrl_pkg::REG_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Hold,
  input  logic             Flush,
  input  logic             ID_Valid,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic [REG_W-1:0] ID_WriteReg,
  output logic [1:0]       FwdSelA,
  output logic [1:0]       FwdSelB,
  output logic             Stall,
  output logic             Bubble
);
  import fwd_hazard_ctrl_pkg::*;
  state_t state, nextState;
  logic [1:0] cnt, nextCnt, selA, selB;
  logic exV, exRW, exMR, memV, memRW, hazard, issued, startStall;
  logic [REG_W-1:0] exDst, memDst;
  fwd_src_sel #(.REG_W(REG_W)) uSelA (
    .src(ID_Rs), .used(ID_UsesRs), .exV(exV), .exRW(exRW), .exDst(exDst),
    .memV(memV), .memRW(memRW), .memDst(memDst), .sel(selA)
  );
  fwd_src_sel #(.REG_W(REG_W)) uSelB (
    .src(ID_Rt), .used(ID_UsesRt), .exV(exV), .exRW(exRW), .exDst(exDst),
    .memV(memV), .memRW(memRW), .memDst(memDst), .sel(selB)
  );
  assign hazard = state == RUN && exV && exMR && exDst != '0 &&
                  ((ID_UsesRs && ID_Rs == exDst) || (ID_UsesRt && ID_Rt == exDst));
  assign Stall = Reset && !Flush && (hazard || state == STALL);
  assign Bubble = !Reset || Stall || Flush || !ID_Valid;
  assign issued = !Bubble;
  // a single-cycle stall needs no STALL state: the load has moved on to MEM by the next edge
  assign startStall = hazard && LOAD_STALL > 1;
  always_comb begin
    nextState = Flush ? RUN : state == STALL ? (cnt == 2'd1 ? RUN : STALL) : startStall ? STALL : RUN;
    nextCnt = Flush ? 2'd0 : state == STALL ? cnt - 2'd1 : startStall ? 2'(LOAD_STALL - 1) : 2'd0;
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= RUN;
      cnt <= 2'd0;
      exV <= 1'b0;
      exRW <= 1'b0;
      exMR <= 1'b0;
      exDst <= '0;
      memV <= 1'b0;
      memRW <= 1'b0;
      memDst <= '0;
      FwdSelA <= FWD_REG;
      FwdSelB <= FWD_REG;
    end else if (!Hold) begin
      state <= nextState;
      cnt <= nextCnt;
      memV <= exV;
      memRW <= exRW;
      memDst <= exDst;
      exV <= issued;
      exRW <= issued && ID_RegWrite;
      exMR <= issued && ID_MemRead;
      exDst <= issued ? ID_WriteReg : '0;
      FwdSelA <= issued ? selA : FWD_REG;
      FwdSelB <= issued ? selB : FWD_REG;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: three instances (LOAD_STALL 1..3) checked against an instruction-level pipeline model
module tb_fwd_hazard_ctrl;
  logic Clk = 0, Reset = 0, Hold = 0, Flush = 0;
  logic idValid = 0, idUsesRs = 0, idUsesRt = 0, idRegWrite = 0, idMemRead = 0;
  logic [4:0] idRs = 0, idRt = 0, idWriteReg = 0;
  logic [1:0] selA[3], selB[3];
  logic stall[3], bubble[3];
  int checks = 0, errors = 0;
  bit started = 0;
  bit eV[3], eRW[3], eMR[3], mV[3], mRW[3];
  logic [4:0] eDst[3], mDst[3];
  int left[3];
  logic [1:0] expA[3], expB[3];
  always #5 Clk = ~Clk;
  for (genvar g = 0; g < 3; g++) begin : gDut
    fwd_hazard_ctrl #(.LOAD_STALL(g + 1), .REG_W(5)) u (
      .Clk(Clk), .Reset(Reset), .Hold(Hold), .Flush(Flush), .ID_Valid(idValid),
      .ID_Rs(idRs), .ID_Rt(idRt), .ID_UsesRs(idUsesRs), .ID_UsesRt(idUsesRt),
      .ID_RegWrite(idRegWrite), .ID_MemRead(idMemRead), .ID_WriteReg(idWriteReg),
      .FwdSelA(selA[g]), .FwdSelB(selB[g]), .Stall(stall[g]), .Bubble(bubble[g])
    );
  end
  function automatic bit loadUse(int k);
    return eV[k] && eMR[k] && eDst[k] != 0 &&
           ((idUsesRs && idRs == eDst[k]) || (idUsesRt && idRt == eDst[k]));
  endfunction
  function automatic bit mStall(int k);
    return Reset && !Flush && (left[k] > 0 || loadUse(k));
  endfunction
  function automatic bit mBubble(int k);
    return !Reset || mStall(k) || Flush || !idValid;
  endfunction
  // youngest older producer wins; $0 and non-writers never forward
  function automatic logic [1:0] fsel(int k, bit used, logic [4:0] s);
    if (!used || s == 0) return 2'd0;
    if (eV[k] && eRW[k] && eDst[k] == s) return 2'd1;
    if (mV[k] && mRW[k] && mDst[k] == s) return 2'd2;
    return 2'd0;
  endfunction
  task automatic chk(string name, int k, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ls=%0d actual %0d expected %0d at %0t", name, k + 1, act, exp, $time);
    end
  endtask
  always @(posedge Clk) begin
    started <= 1;
    for (int k = 0; k < 3; k++) begin
      automatic bit iss = !mBubble(k);
      if (!Reset) begin
        eV[k] <= 0; eRW[k] <= 0; eMR[k] <= 0; eDst[k] <= 0;
        mV[k] <= 0; mRW[k] <= 0; mDst[k] <= 0;
        left[k] <= 0; expA[k] <= 0; expB[k] <= 0;
      end else if (!Hold) begin
        expA[k] <= iss ? fsel(k, idUsesRs, idRs) : 2'd0;
        expB[k] <= iss ? fsel(k, idUsesRt, idRt) : 2'd0;
        mV[k] <= eV[k]; mRW[k] <= eRW[k]; mDst[k] <= eDst[k];
        eV[k] <= iss; eRW[k] <= iss && idRegWrite; eMR[k] <= iss && idMemRead;
        eDst[k] <= iss ? idWriteReg : 5'd0;
        left[k] <= Flush ? 0 : left[k] > 0 ? left[k] - 1 : loadUse(k) ? k : 0;
      end
    end
  end
  always @(negedge Clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk("model_stall", k, 2'(stall[k]), 2'(mStall(k)));
        chk("model_bubble", k, 2'(bubble[k]), 2'(mBubble(k)));
        chk("model_selA", k, selA[k], expA[k]);
        chk("model_selB", k, selB[k], expB[k]);
      end
    end
  end
  task automatic setId(bit v, logic [4:0] rs, logic [4:0] rt, bit ur, bit ut, bit rw, bit mr, logic [4:0] wr);
    idValid = v; idRs = rs; idRt = rt; idUsesRs = ur; idUsesRt = ut;
    idRegWrite = rw; idMemRead = mr; idWriteReg = wr;
  endtask
  task automatic nop();
    setId(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic loadThenUse();
    setId(1, 9, 0, 1, 0, 1, 1, 8);
    step();
    setId(1, 8, 8, 1, 1, 1, 0, 10);
  endtask
  initial begin
    repeat (2) step();
    @(negedge Clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_stall", k, 2'(stall[k]), 2'd0);
      chk("rst_bubble", k, 2'(bubble[k]), 2'd1);
      chk("rst_selA", k, selA[k], 2'd0);
    end
    step();
    Reset = 1;
    setId(1, 1, 2, 1, 1, 1, 0, 3);
    step();
    setId(1, 3, 5, 1, 1, 1, 0, 4);
    @(negedge Clk);
    chk("exfwd_nostall", 0, 2'(stall[0]), 2'd0);
    step();
    nop();
    @(negedge Clk);
    for (int k = 0; k < 3; k++) begin
      chk("exfwd_selA", k, selA[k], 2'd1);
      chk("exfwd_selB", k, selB[k], 2'd0);
    end
    step();
    setId(1, 1, 2, 1, 1, 1, 0, 3);
    step();
    nop();
    step();
    setId(1, 7, 3, 1, 1, 1, 0, 6);
    step();
    nop();
    @(negedge Clk);
    chk("memfwd_selA", 0, selA[0], 2'd0);
    chk("memfwd_selB", 0, selB[0], 2'd2);
    setId(1, 1, 2, 1, 1, 1, 0, 0);
    step();
    setId(1, 0, 0, 1, 1, 1, 0, 4);
    step();
    nop();
    @(negedge Clk);
    chk("r0_selA", 0, selA[0], 2'd0);
    chk("r0_selB", 0, selB[0], 2'd0);
    step();
    step();
    loadThenUse();
    @(negedge Clk);
    for (int k = 0; k < 3; k++) begin
      chk("lu_stall1", k, 2'(stall[k]), 2'd1);
      chk("lu_bubble1", k, 2'(bubble[k]), 2'd1);
    end
    step();
    @(negedge Clk);
    chk("lu_stall2", 0, 2'(stall[0]), 2'd0);
    chk("lu_stall2", 1, 2'(stall[1]), 2'd1);
    chk("lu_stall2", 2, 2'(stall[2]), 2'd1);
    step();
    @(negedge Clk);
    chk("lu_selA", 0, selA[0], 2'd2);
    chk("lu_selB", 0, selB[0], 2'd2);
    chk("lu_stall3", 1, 2'(stall[1]), 2'd0);
    chk("lu_stall3", 2, 2'(stall[2]), 2'd1);
    step();
    @(negedge Clk);
    chk("lu_selA", 1, selA[1], 2'd0);
    chk("lu_selB", 1, selB[1], 2'd0);
    chk("lu_stall4", 2, 2'(stall[2]), 2'd0);
    nop();
    step();
    @(negedge Clk);
    chk("lu_selA", 2, selA[2], 2'd0);
    chk("lu_selB", 2, selB[2], 2'd0);
    step();
    loadThenUse();
    step();
    Flush = 1;
    @(negedge Clk);
    chk("flush_stall", 2, 2'(stall[2]), 2'd0);
    chk("flush_bubble", 2, 2'(bubble[2]), 2'd1);
    step();
    Flush = 0;
    @(negedge Clk);
    chk("flush_run", 2, 2'(stall[2]), 2'd0);
    nop();
    step();
    step();
    loadThenUse();
    step();
    Hold = 1;
    repeat (3) begin
      @(negedge Clk);
      chk("hold_stall", 2, 2'(stall[2]), 2'd1);
      step();
    end
    Hold = 0;
    @(negedge Clk);
    chk("resume_stall_a", 2, 2'(stall[2]), 2'd1);
    step();
    @(negedge Clk);
    chk("resume_stall_b", 2, 2'(stall[2]), 2'd1);
    step();
    @(negedge Clk);
    chk("resume_done", 2, 2'(stall[2]), 2'd0);
    nop();
    step();
    step();
    loadThenUse();
    step();
    Reset = 0;
    @(negedge Clk);
    for (int k = 0; k < 3; k++) begin
      chk("midrst_stall", k, 2'(stall[k]), 2'd0);
      chk("midrst_bubble", k, 2'(bubble[k]), 2'd1);
    end
    step();
    @(negedge Clk);
    chk("midrst_selA", 2, selA[2], 2'd0);
    chk("midrst_selB", 2, selB[2], 2'd0);
    Reset = 1;
    setId(1, 1, 2, 1, 1, 1, 0, 1);
    step();
    setId(1, 1, 1, 1, 1, 1, 0, 2);
    step();
    nop();
    @(negedge Clk);
    for (int k = 0; k < 3; k++) begin
      chk("postrst_selA", k, selA[k], 2'd1);
      chk("postrst_selB", k, selB[k], 2'd1);
    end
    repeat (3000) begin
      Reset = $urandom_range(99) != 0;
      Hold = $urandom_range(7) == 0;
      Flush = $urandom_range(15) == 0;
      setId(1'($urandom_range(3) != 0), 5'($urandom_range(3)), 5'($urandom_range(3)),
            1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(2) == 0), 5'($urandom_range(3)));
      step();
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
